boot_loader: RTL and testbench

Serial program loader upstream of the 16-bit-port memory block. It consumes a byte stream from the UART receiver and parses framed load records (sync, start address, word count, data, checksum). It drives the memory block's write port one 16-bit word at a time, and holds the CPU off while a frame is in flight.

---
 rtl/boot_loader.sv | 150 +++++++++++++++
 tb/tb_boot_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Serial frame loader: parses SYNC/ADDR/LEN/DATA/CHK byte records from a UART
// stream and writes 16-bit words to memory, holding the CPU off while a frame is open.
module boot_loader #(
  parameter int          ADDRESS_WIDTH  = 16,
  parameter int          TIMEOUT_CYCLES = 65535,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_write_address,
  output logic [15:0]              mem_data_out,
  output logic                     cpu_hold,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK
  } state_t;

  // Idle counter holds values 0 .. TIMEOUT_CYCLES-1; expiry is detected at the last value.
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t r_state;
  state_t w_state_next;

  logic [15:0]              r_addr;
  logic [7:0]               r_len_hi;
  logic [15:0]              r_ptr;
  logic [15:0]              r_cnt;
  logic [7:0]               r_hi;
  logic [7:0]               r_sum;
  logic [TW-1:0]            r_tmo;
  logic                     r_we;
  logic [ADDRESS_WIDTH-1:0] r_waddr;
  logic [15:0]              r_wdata;
  logic                     r_done;
  logic                     r_error;
  logic                     r_busy;

  logic       w_timeout;
  logic       w_sync;
  logic [7:0] w_sum_add;
  logic       w_we_next;
  logic       w_done_next;
  logic       w_error_next;

  assign w_timeout = (r_state != S_IDLE) && !rx_valid && (r_tmo == TMO_LAST);
  assign w_sync    = (r_state == S_IDLE) && rx_valid && (rx_data == SYNC_BYTE);
  assign w_sum_add = r_sum + rx_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = S_IDLE;
    end else if (rx_valid) begin
      case (r_state)
        S_IDLE:    if (rx_data == SYNC_BYTE) w_state_next = S_ADDR_HI;
        S_ADDR_HI: w_state_next = S_ADDR_LO;
        S_ADDR_LO: w_state_next = S_LEN_HI;
        S_LEN_HI:  w_state_next = S_LEN_LO;
        S_LEN_LO:  w_state_next = ({r_len_hi, rx_data} == 16'h0000) ? S_CHECK : S_DATA_HI;
        S_DATA_HI: w_state_next = S_DATA_LO;
        S_DATA_LO: w_state_next = (r_cnt == 16'h0001) ? S_CHECK : S_DATA_HI;
        S_CHECK:   w_state_next = S_IDLE;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_we_next    = (r_state == S_DATA_LO) && rx_valid;
    w_done_next  = (r_state == S_CHECK) && rx_valid && (w_sum_add == 8'h00);
    w_error_next = r_error;
    if (w_sync)
      w_error_next = 1'b0;
    if (w_timeout || ((r_state == S_CHECK) && rx_valid && (w_sum_add != 8'h00)))
      w_error_next = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_len_hi <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_sum    <= '0;
      r_tmo    <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_we    <= w_we_next;
      r_done  <= w_done_next;
      r_error <= w_error_next;
      r_busy  <= (w_state_next != S_IDLE);

      if (r_state == S_IDLE || rx_valid || w_timeout) r_tmo <= '0;
      else                                             r_tmo <= r_tmo + 1'b1;

      if (w_sync)
        r_sum <= 8'h00;
      else if (rx_valid && r_state != S_IDLE)
        r_sum <= w_sum_add;

      if (rx_valid) begin
        case (r_state)
          S_ADDR_HI: r_addr[15:8] <= rx_data;
          S_ADDR_LO: r_addr[7:0]  <= rx_data;
          S_LEN_HI:  r_len_hi     <= rx_data;
          S_LEN_LO: begin
            r_cnt <= {r_len_hi, rx_data};
            r_ptr <= r_addr;
          end
          S_DATA_HI: r_hi <= rx_data;
          S_DATA_LO: begin
            r_wdata <= {r_hi, rx_data};
            r_waddr <= r_ptr[ADDRESS_WIDTH-1:0];
            r_ptr   <= r_ptr + 16'h0001;
            r_cnt   <= r_cnt - 16'h0001;
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_write_enable  = r_we;
  assign mem_write_address = r_waddr;
  assign mem_data_out      = r_wdata;
  assign cpu_hold          = r_busy;
  assign busy              = r_busy;
  assign done              = r_done;
  assign error             = r_error;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: expected writes go to a scoreboard queue as
// bytes are driven and are popped by a negedge monitor when the strobe appears.
module tb_boot_loader;

  localparam int T = 16;

  logic        clock;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        we;
  logic [15:0] waddr;
  logic [15:0] wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  int          exp_done = 0;
  logic        prev_we = 1'b0;
  logic [31:0] exp_q[$];
  logic [15:0] words[4];

  boot_loader #(.ADDRESS_WIDTH(16), .TIMEOUT_CYCLES(T), .SYNC_BYTE(8'hA5)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_write_enable(we), .mem_write_address(waddr), .mem_data_out(wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    logic [31:0] e;
    if (we) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr_data", {waddr, wdata}, e);
        $display("write addr=%h data=%h expected=%h", waddr, wdata, e);
      end
      chk("strobe_one_cycle", 32'(prev_we), 32'd0);
    end
    prev_we = we;
    if (done) done_seen++;
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] addr, input int len, input logic [7:0] bad);
    logic [7:0]  sum;
    logic [15:0] a;
    logic [15:0] l;
    sum = 8'h00;
    a   = addr;
    l   = 16'(len);
    send(8'hA5);
    chk("busy_after_sync", 32'(busy), 32'd1);
    chk("hold_after_sync", 32'(cpu_hold), 32'd1);
    chk("error_cleared_by_sync", 32'(error), 32'd0);
    send(addr[15:8]); sum += addr[15:8];
    send(addr[7:0]);  sum += addr[7:0];
    send(l[15:8]);    sum += l[15:8];
    send(l[7:0]);     sum += l[7:0];
    for (int i = 0; i < len; i++) begin
      send(words[i][15:8]); sum += words[i][15:8];
      exp_q.push_back({a, words[i]});
      send(words[i][7:0]);  sum += words[i][7:0];
      a = a + 16'h0001;
    end
    chk("hold_before_chk", 32'(cpu_hold), 32'd1);
    send((8'h00 - sum) + bad);
    chk("done_after_chk", 32'(done), (bad == 8'h00) ? 32'd1 : 32'd0);
    chk("error_after_chk", 32'(error), (bad == 8'h00) ? 32'd0 : 32'd1);
    chk("busy_after_chk", 32'(busy), 32'd0);
    chk("hold_after_chk", 32'(cpu_hold), 32'd0);
    if (bad == 8'h00) exp_done++;
    $display("frame addr=%h len=%0d bad=%0d done=%b error=%b", addr, len, bad, done, error);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #3;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(waddr), 32'd0);
    chk("rst_data", 32'(wdata), 32'd0);
    chk("rst_busy", {busy, cpu_hold, done, error}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Good two-word frame, bytes back to back
    words[0] = 16'h1234; words[1] = 16'hABCD;
    send_frame(16'h0100, 2, 8'h00);

    // Same frame with a corrupted checksum: writes happen, error sticks
    send_frame(16'h0100, 2, 8'h01);
    idle(3);
    chk("error_sticky", 32'(error), 32'd1);
    send(8'h12);
    send(8'h00);
    chk("idle_ignores_bytes", 32'(busy), 32'd0);

    // Pointer wrap from FFFF to 0000; sync clears the sticky error
    words[0] = 16'h1122; words[1] = 16'h3344;
    send_frame(16'hFFFF, 2, 8'h00);

    // Zero-length frame
    send_frame(16'h0010, 0, 8'h00);

    // Timeout after the first DATA_HI byte
    send(8'hA5); send(8'h00); send(8'h20); send(8'h00); send(8'h01); send(8'h55);
    idle(T - 1);
    chk("busy_before_expiry", 32'(busy), 32'd1);
    idle(1);
    chk("busy_after_timeout", 32'(busy), 32'd0);
    chk("error_after_timeout", 32'(error), 32'd1);
    chk("hold_after_timeout", 32'(cpu_hold), 32'd0);
    $display("timeout busy=%b error=%b", busy, error);

    // A byte on the expiry cycle keeps the frame alive
    send(8'hA5);
    chk("error_cleared_resync", 32'(error), 32'd0);
    send(8'h00); send(8'h30); send(8'h00); send(8'h01); send(8'h66);
    idle(T - 1);
    exp_q.push_back({16'h0030, 16'h6677});
    send(8'h77);
    chk("alive_after_expiry_byte", 32'(busy), 32'd1);
    chk("no_error_expiry_byte", 32'(error), 32'd0);
    send(8'hF2);
    chk("done_after_survivor", 32'(done), 32'd1);
    exp_done++;
    $display("expiry survivor done=%b error=%b", done, error);

    // Reset in DATA_LO of the second word
    send(8'hA5); send(8'h00); send(8'h40); send(8'h00); send(8'h02); send(8'h01);
    exp_q.push_back({16'h0040, 16'h0102});
    send(8'h02);
    send(8'h03);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_we", 32'(we), 32'd0);
    chk("async_rst_addr", 32'(waddr), 32'd0);
    chk("async_rst_busy", {busy, cpu_hold, done, error}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    send(8'h04);
    send(8'h00);
    idle(2);
    chk("ignored_after_reset", 32'(busy), 32'd0);
    $display("reset mid-frame busy=%b we=%b", busy, we);

    // Recovery with a fresh frame
    send_frame(16'h0010, 0, 8'h00);

    idle(3);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("done_pulse_count", 32'(done_seen), 32'(exp_done));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
